// File: rtl/irq_ctrl4_if.sv
// Signal bundle for the 4-channel interrupt controller: request side
// (irq, mask, ack, overrun clear) and presentation side (valid, id, status).
interface irq_ctrl4_if;
    logic [3:0] irq;
    logic [3:0] mask;
    logic       irq_ack;
    logic       clr_ovr;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] overrun;

    // Consumer / stimulus side: drives requests, observes presentation.
    modport master (
        output irq, mask, irq_ack, clr_ovr,
        input  irq_valid, irq_id, pending, overrun
    );

    // Controller side.
    modport slave (
        input  irq, mask, irq_ack, clr_ovr,
        output irq_valid, irq_id, pending, overrun
    );
endinterface

// File: rtl/prio_encoder4x2.sv
// Fixed-priority 4:2 encoder; bit 3 has the highest priority.
module prio_encoder4x2 (
    input  logic [3:0] req,
    output logic [1:0] id,
    output logic       any
);

    // Pick the highest set request index.
    always_comb begin
        id  = 2'd0;
        any = 1'b1;
        casez (req)
            4'b1???: id = 2'd3;
            4'b01??: id = 2'd2;
            4'b001?: id = 2'd1;
            4'b0001: id = 2'd0;
            default: any = 1'b0;
        endcase
    end

endmodule

// File: rtl/irq_ctrl4.sv
// Four-channel interrupt controller: synchronises raw request lines, latches
// rising events into pending bits (with sticky overrun on coalescing) and
// presents the highest-priority unmasked pending channel until acknowledged.
module irq_ctrl4 #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] irq,
    input  logic [3:0] mask,
    input  logic       irq_ack,
    input  logic       clr_ovr,
    output logic       irq_valid,
    output logic [1:0] irq_id,
    output logic [3:0] pending,
    output logic [3:0] overrun
);

    localparam logic STATE_IDLE    = 1'b0;
    localparam logic STATE_PRESENT = 1'b1;

    logic       state;
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] hist_q;
    logic [3:0] rise;
    logic [3:0] ack_clr;
    logic [3:0] eligible;
    logic [1:0] enc_id;
    logic       enc_any;

    // A rising event is a 0->1 step seen at the last synchroniser stage.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Bit of the presented channel that an acknowledge releases this edge.
    assign ack_clr = (state == STATE_PRESENT && irq_ack) ? (4'b0001 << irq_id) : 4'b0000;

    // Masked channels keep latching but never compete for presentation.
    assign eligible = pending & ~mask;

    prio_encoder4x2 u_prio (
        .req (eligible),
        .id  (enc_id),
        .any (enc_any)
    );

    // Synchroniser chain per request line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= 4'b0000;
            end
        end else begin
            sync_q[0] <= irq;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Edge history, pending latch and sticky overrun flags.
    // A new event on the channel being acked wins over the ack and is not
    // an overrun; a new overrun wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= 4'b0000;
            pending <= 4'b0000;
            overrun <= 4'b0000;
        end else begin
            hist_q  <= sync_q[SYNC_STAGES-1];
            pending <= (pending & ~ack_clr) | rise;
            overrun <= (clr_ovr ? 4'b0000 : overrun) | (rise & pending & ~ack_clr);
        end
    end

    // Presentation FSM: load and hold one channel until it is acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= STATE_IDLE;
            irq_valid <= 1'b0;
            irq_id    <= 2'd0;
        end else begin
            case (state)
                STATE_IDLE: begin
                    if (enc_any) begin
                        irq_id    <= enc_id;
                        irq_valid <= 1'b1;
                        state     <= STATE_PRESENT;
                    end
                end
                STATE_PRESENT: begin
                    if (irq_ack) begin
                        irq_valid <= 1'b0;
                        state     <= STATE_IDLE;
                    end
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/irq_ctrl4.md
IRQ_CTRL4 -- requirements
Module: irq_ctrl4

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchroniser flops per irq input (legal values 2..3).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port irq, input, 4, raw asynchronous request lines; channel 3 has the highest priority and channel 0 the lowest.
REQ-005 The block SHALL have port mask, input, 4, where 1 blocks that channel from presentation (pending still latches).
REQ-006 The block SHALL have port irq_ack, input, 1, consumer acknowledge for the presented id.
REQ-007 The block SHALL have port clr_ovr, input, 1, a one-cycle pulse that clears all overrun flags.
REQ-008 The block SHALL have port irq_valid, output, 1, meaning a request is presented.
REQ-009 The block SHALL have port irq_id, output, 2, the index of the presented channel.
REQ-010 The block SHALL have port pending, output, 4, the latched request bits.
REQ-011 The block SHALL have port overrun, output, 4, a sticky flag per channel set when an event was coalesced.

Function
REQ-012 Each irq bit SHALL pass through SYNC_STAGES flops; a 0->1 transition at the last stage SHALL be a rising event.
REQ-013 A rising event SHALL set pending[i] on the same edge that registers it; pending SHALL be visible after edge k+SYNC_STAGES, where edge k is the first edge sampling irq high.
REQ-014 Levels and falling edges SHALL NOT set pending; a held-high irq SHALL produce exactly one event.
REQ-015 A rising event on a channel whose pending bit is already 1 SHALL set overrun[i] and leave pending[i] at 1.
REQ-016 The FSM SHALL have two states, IDLE and PRESENT.
REQ-017 In IDLE, if (pending & ~mask) != 0, the FSM SHALL load irq_id with the highest set index, assert irq_valid on the next edge, and move to PRESENT.
REQ-018 In PRESENT, irq_valid and irq_id SHALL be held stable regardless of new events or mask changes, with no preemption and no withdrawal.
REQ-019 In PRESENT, irq_ack=1 at an edge SHALL clear pending[irq_id], deassert irq_valid, and return the FSM to IDLE, giving at least one idle cycle between presentations.
REQ-020 irq_ack in IDLE SHALL be ignored.
REQ-021 A rising event on the acked channel at the same edge as its ack SHALL win: pending stays 1, overrun is not set, and the channel is re-presented later.
REQ-022 clr_ovr SHALL clear all overrun bits; a simultaneous overrun-setting event SHALL win for that bit.
REQ-023 Latency from irq rising (edge k) to irq_valid high with the FSM idle and no masking SHALL be edge k+SYNC_STAGES+1, which is 3 edges by default.

Reset
REQ-024 rst_n low SHALL asynchronously clear all synchroniser flops, edge-detect history, pending, overrun, irq_valid, and irq_id to 0, and set the FSM to IDLE.
REQ-025 Reset asserted in PRESENT SHALL drop irq_valid immediately without any ack, and all latched requests SHALL be lost.
REQ-026 After rst_n deasserts, an irq line already high SHALL register as one rising event, because the history resets to 0.

Structure
REQ-027 The design SHALL have no shared package; the state encoding (IDLE=0, PRESENT=1) SHALL be a localparam inside irq_ctrl4.
REQ-028 Priority selection SHALL instantiate the existing prio_encoder4x2 sub-module, with its input driven by pending & ~mask and its output feeding the irq_id load.
REQ-029 The design SHALL have no other sub-modules, and it SHALL contain no combinational path from irq to any output.

Verification
REQ-030 Reset, then pulse irq=4'b0100 for 1 cycle -> pending=4'b0100 after edge 2, and irq_valid=1 with irq_id=2 after edge 3; irq_ack -> pending=0 and irq_valid=0.
REQ-031 With irq=4'b1010 simultaneously -> irq_id=3 first; after ack, one idle cycle, then irq_id=1; after ack, pending=0.
REQ-032 Present ch0, then raise irq[3] before ack -> irq_id stays 0 until ack, then ch3 is presented.
REQ-033 With mask=4'b1000, irq=4'b1000 -> pending=4'b1000 and irq_valid=0; set mask=0 -> irq_valid=1 with irq_id=3.
REQ-034 Two rising pulses on irq[1] without ack -> overrun=4'b0010 and a single presentation; clr_ovr -> overrun=0.
REQ-035 Assert rst_n=0 during PRESENT -> irq_valid=0 immediately and pending=0; with irq[0] held high through reset -> after release, one event and irq_id=0.
